// File: rtl/alu_param_pkg.sv
// -----------------------------------------------------------------------------
// alu_param_pkg
// Shared definitions for the alu_param multi-cycle ALU:
//   - default operand width
//   - op_code encodings (add, sub, signed multiply, unsigned divide)
//   - controller state encoding (legacy-style localparam constants)
//   - radix-4 Booth recode constants and the recode helper function
// Optional feature macro: ALU_PARAM_DIV_EN. When it is defined, the LOAD_M
// and CORRECT states exist. Without it those encodings are not declared,
// because no divide datapath is built.
// -----------------------------------------------------------------------------
package alu_param_pkg;

    localparam int ALU_PARAM_WIDTH = 8;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD_Y  = 3'd1;
    localparam logic [2:0] ST_EXEC    = 3'd3;
    localparam logic [2:0] ST_OUT_HI  = 3'd5;
    localparam logic [2:0] ST_OUT_LO  = 3'd6;
`ifdef ALU_PARAM_DIV_EN
    localparam logic [2:0] ST_LOAD_M  = 3'd2;
    localparam logic [2:0] ST_CORRECT = 3'd4;
`endif

    // Partial-product selection for one radix-4 Booth digit:
    // zero -> add nothing, dbl -> use 2M instead of M, neg -> subtract.
    typedef struct packed {
        logic zero;
        logic dbl;
        logic neg;
    } booth_sel_t;

    localparam booth_sel_t BOOTH_ZERO = '{zero: 1'b1, dbl: 1'b0, neg: 1'b0};
    localparam booth_sel_t BOOTH_POS1 = '{zero: 1'b0, dbl: 1'b0, neg: 1'b0};
    localparam booth_sel_t BOOTH_POS2 = '{zero: 1'b0, dbl: 1'b1, neg: 1'b0};
    localparam booth_sel_t BOOTH_NEG2 = '{zero: 1'b0, dbl: 1'b1, neg: 1'b1};
    localparam booth_sel_t BOOTH_NEG1 = '{zero: 1'b0, dbl: 1'b0, neg: 1'b1};

    // Recode the multiplier bit triple {q[1], q[0], q[-1]} into a digit
    // in {-2, -1, 0, +1, +2}.
    function automatic booth_sel_t booth_recode(input logic [2:0] bits);
        booth_sel_t sel;
        case (bits)
            3'b000, 3'b111: sel = BOOTH_ZERO;
            3'b001, 3'b010: sel = BOOTH_POS1;
            3'b011:         sel = BOOTH_POS2;
            3'b100:         sel = BOOTH_NEG2;
            default:        sel = BOOTH_NEG1;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/alu_param_adder_rca.sv
// -----------------------------------------------------------------------------
// adder_rca
// Plain ripple-carry adder used as the single shared datapath adder of
// alu_param.
// Ports:
//   a, b  : N-bit addends
//   cin   : carry in (set to 1 together with an inverted b to subtract)
//   sum   : N-bit sum
//   cout  : carry out of the top bit
// -----------------------------------------------------------------------------
module adder_rca #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[N];

endmodule

// File: rtl/alu_param.sv
// -----------------------------------------------------------------------------
// alu_param
// Multi-cycle ALU with a word-serial operand/result stream.
// Operations: add, sub (one cycle), signed multiply (radix-4 Booth), and
// unsigned non-restoring divide.
// Optional feature macro: ALU_PARAM_DIV_EN. When it is undefined, op_code 11
// reports an error word after loading X and Y.
// Parameter:
//   WIDTH     : operand width; it must be even and at least 4.
// Ports:
//   clk       : clock, rising edge
//   reset     : asynchronous reset, active low
//   BEGIN     : start request, sampled only while idle
//   op_code   : 00 add, 01 sub, 10 signed mul, 11 unsigned div
//   inbus     : operand words (X/A, then Y/Q, then M for divide)
//   outbus    : result words, 0 when out_valid is low
//   out_valid : outbus carries a result word
//   END       : pulse on the last result word
//   busy      : high whenever not idle
//   err       : overflow/error flag, qualified by out_valid
// -----------------------------------------------------------------------------
module alu_param
    import alu_param_pkg::*;
#(
    parameter int WIDTH = ALU_PARAM_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             BEGIN,
    input  logic [1:0]       op_code,
    input  logic [WIDTH-1:0] inbus,
    output logic [WIDTH-1:0] outbus,
    output logic             out_valid,
    output logic             END,
    output logic             busy,
    output logic             err
);

    localparam int AW = WIDTH + 1;
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] MUL_STEPS = CW'(WIDTH / 2);
`ifdef ALU_PARAM_DIV_EN
    localparam logic [CW-1:0] DIV_STEPS = CW'(WIDTH);
`endif

    logic [2:0]       state;
    logic [1:0]       op_reg;
    logic [AW-1:0]    reg_a;
    logic [WIDTH-1:0] reg_q;
    logic [WIDTH-1:0] reg_m;
    logic             qm1;
    logic [CW-1:0]    cnt;
    logic             err_flag;

    logic [AW-1:0]    add_a;
    logic [AW-1:0]    add_b_raw;
    logic [AW-1:0]    add_b;
    logic             add_sub;
    logic [AW-1:0]    add_sum;
    logic             add_cout;
    logic             mul_top;
    logic [AW-1:0]    m_ext;
    logic [AW-1:0]    m2_ext;
    logic             zero_out;
    booth_sel_t       booth;
`ifdef ALU_PARAM_DIV_EN
    logic [AW-1:0]    div_shift;
`endif

    assign m_ext  = {reg_m[WIDTH-1], reg_m};
    // 2M sign-extended to WIDTH+1 bits is just M with a zero appended
    assign m2_ext = {reg_m, 1'b0};
    assign booth  = booth_recode({reg_q[1:0], qm1});
`ifdef ALU_PARAM_DIV_EN
    assign div_shift = {reg_a[WIDTH-1:0], reg_q[WIDTH-1]};
`endif

    // Operand steering for the shared adder; subtraction is done as
    // a + ~b + 1 so one adder covers every step.
    always_comb begin
        add_a     = reg_a;
        add_b_raw = '0;
        add_sub   = 1'b0;
        case (state)
            ST_EXEC: begin
                case (op_reg)
                    OP_ADD, OP_SUB: begin
                        add_a     = m_ext;
                        add_b_raw = {reg_q[WIDTH-1], reg_q};
                        add_sub   = (op_reg == OP_SUB);
                    end
                    OP_MUL: begin
                        add_b_raw = booth.zero ? '0 : (booth.dbl ? m2_ext : m_ext);
                        add_sub   = booth.neg;
                    end
`ifdef ALU_PARAM_DIV_EN
                    OP_DIV: begin
                        add_a     = div_shift;
                        add_b_raw = {1'b0, reg_m};
                        add_sub   = ~reg_a[AW-1];
                    end
`endif
                    default: ;
                endcase
            end
`ifdef ALU_PARAM_DIV_EN
            ST_CORRECT: begin
                add_b_raw = {1'b0, reg_m};
            end
`endif
            default: ;
        endcase
    end

    assign add_b = add_b_raw ^ {AW{add_sub}};

    adder_rca #(
        .N (AW)
    ) u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_sub),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // A Booth step can exceed the WIDTH+1-bit accumulator before the shift;
    // this recovers the true sign bit of the WIDTH+2-bit sum from the carry.
    assign mul_top = add_a[AW-1] ^ add_b[AW-1] ^ add_cout;

    // Controller and datapath registers. For multiply and divide the EXEC
    // cycle that sees the terminal count only hands over to the next state,
    // so exactly the required number of iterations run and the counter
    // never has to wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            op_reg   <= OP_ADD;
            reg_a    <= '0;
            reg_q    <= '0;
            reg_m    <= '0;
            qm1      <= 1'b0;
            cnt      <= '0;
            err_flag <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (BEGIN) begin
                        op_reg   <= op_code;
                        reg_a    <= {1'b0, inbus};
                        reg_m    <= inbus;
                        err_flag <= 1'b0;
                        state    <= ST_LOAD_Y;
                    end
                end
                ST_LOAD_Y: begin
                    reg_q <= inbus;
                    qm1   <= 1'b0;
                    cnt   <= '0;
                    case (op_reg)
                        OP_MUL: begin
                            reg_a <= '0;
                            state <= ST_EXEC;
                        end
                        OP_DIV: begin
`ifdef ALU_PARAM_DIV_EN
                            state <= ST_LOAD_M;
`else
                            err_flag <= 1'b1;
                            state    <= ST_OUT_LO;
`endif
                        end
                        default: state <= ST_EXEC;
                    endcase
                end
`ifdef ALU_PARAM_DIV_EN
                ST_LOAD_M: begin
                    reg_m <= inbus;
                    cnt   <= '0;
                    // A >= M also catches M = 0; the quotient would not fit
                    if (reg_a[WIDTH-1:0] >= inbus) begin
                        err_flag <= 1'b1;
                        state    <= ST_OUT_HI;
                    end else begin
                        state <= ST_EXEC;
                    end
                end
`endif
                ST_EXEC: begin
                    case (op_reg)
                        OP_ADD, OP_SUB: begin
                            reg_q    <= add_sum[WIDTH-1:0];
                            err_flag <= add_sum[WIDTH] ^ add_sum[WIDTH-1];
                            state    <= ST_OUT_LO;
                        end
                        OP_MUL: begin
                            if (cnt == MUL_STEPS) begin
                                state <= ST_OUT_HI;
                            end else begin
                                reg_a <= {mul_top, mul_top, add_sum[AW-1:2]};
                                reg_q <= {add_sum[1:0], reg_q[WIDTH-1:2]};
                                qm1   <= reg_q[1];
                                cnt   <= cnt + CW'(1);
                            end
                        end
`ifdef ALU_PARAM_DIV_EN
                        OP_DIV: begin
                            if (cnt == DIV_STEPS) begin
                                state <= ST_CORRECT;
                            end else begin
                                reg_a <= add_sum;
                                reg_q <= {reg_q[WIDTH-2:0], ~add_sum[AW-1]};
                                cnt   <= cnt + CW'(1);
                            end
                        end
`endif
                        default: state <= ST_OUT_LO;
                    endcase
                end
`ifdef ALU_PARAM_DIV_EN
                ST_CORRECT: begin
                    if (reg_a[AW-1]) begin
                        reg_a <= add_sum;
                    end
                    state <= ST_OUT_HI;
                end
`endif
                ST_OUT_HI: state <= ST_OUT_LO;
                ST_OUT_LO: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign out_valid = (state == ST_OUT_HI) || (state == ST_OUT_LO);
    assign END       = (state == ST_OUT_LO);
    assign err       = out_valid & err_flag;

    // A flagged divide reports zero words whatever the registers hold
    assign zero_out  = err_flag & (op_reg == OP_DIV);

    // The high word always lives in the accumulator, the low word in Q
    always_comb begin
        outbus = '0;
        if (out_valid && !zero_out) begin
            outbus = (state == ST_OUT_HI) ? reg_a[WIDTH-1:0] : reg_q;
        end
    end

endmodule
